multdiv: RTL and testbench
==========================

# multdiv

Iterative signed 32-bit multiply/divide unit for the execute stage of the pipelined MIPS CPU. It is the sequential counterpart to the combinational ALU. It accepts a one-cycle start pulse with two operands, runs a fixed-length iteration, and answers with a one-cycle ready strobe, a 32-bit result and an exception flag. The pipeline stalls on it until the strobe arrives.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- data_operandA  input  32  multiplicand / dividend, two's complement; sampled only on a start edge
- data_operandB  input  32  multiplier / divisor, two's complement; sampled only on a start edge
- ctrl_MULT  input  1  one-cycle start pulse for multiply
- ctrl_DIV  input  1  one-cycle start pulse for divide
- data_result  output  32  low 32 bits of the product, or the quotient
- data_exception  output  1  overflow or divide-by-zero; valid with the strobe
- data_resultRDY  output  1  one-cycle completion strobe

## Operation
- States:
  - IDLE: waits for a start.
  - MUL: radix-4 Booth, 16 iterations.
  - DIV: non-restoring division on magnitudes, 32 iterations.
  - DONE: one cycle; drives the strobe.
- IDLE -> MUL on ctrl_MULT; IDLE -> DIV on ctrl_DIV; MUL/DIV -> DONE when the iteration counter reaches its terminal count; DONE -> IDLE.
- Start edge: operands are latched and the 6-bit iteration counter is cleared. The operand inputs are don't-care afterwards.
- Simultaneous starts: ctrl_MULT and ctrl_DIV both high on the same edge is treated as a multiply.
- Restart: a start pulse in MUL, DIV or DONE aborts the current operation and restarts it with the new operands. The aborted operation produces no strobe.
- Multiply:
  - Forms the full 64-bit signed product.
  - data_result = product[31:0].
  - data_exception = 1 iff product[63:31] is not all-equal, i.e. the result does not fit in signed 32 bits.
- Divide:
  - Quotient truncates toward zero; the sign is A[31]^B[31]. The remainder is discarded.
  - B == 0: data_result = 0, data_exception = 1.
  - A == 0x80000000 and B == 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
  - Otherwise data_exception = 0.
- data_result and data_exception are registered. They update only on the edge entering DONE and hold until the next DONE or reset.

## Timing
- Reset values: data_result = 0, data_exception = 0, data_resultRDY = 0, state = IDLE, counter = 0.
- Let E0 be the edge on which the start is sampled.
  - Multiply: iterations on E1..E16; the edge at E17 enters DONE. data_resultRDY is high for the cycle after E17.
  - Divide: iterations on E1..E32; the edge at E33 enters DONE. data_resultRDY is high for the cycle after E33.
- The divide-by-zero and overflow cases keep the full 32-iteration latency, so latency is data-independent.
- data_resultRDY is high for exactly one cycle per completed operation. It is never high in IDLE, MUL or DIV.
- Back-to-back operations: a start sampled on the DONE edge is accepted. The strobe of the finishing operation still occurs; the new operation's E0 is that edge.
- Reset during MUL, DIV or DONE: the next edge forces IDLE and zeroes all outputs. No strobe follows.
- Reset has priority over a start on the same edge.

## Test plan
- Multiply, positive × negative: A = 7, B = -3, pulse ctrl_MULT -> strobe exactly 17 cycles after the start edge; data_result = 0xFFFFFFEB, exception = 0.
- Multiply overflow: A = 0x00010000, B = 0x00010000 -> data_result = 0x00000000, exception = 1. Also A = 0xFFFFFFFF, B = 0xFFFFFFFF -> result 1, exception 0.
- Divide, truncation toward zero: A = -7, B = 2 -> strobe 33 cycles after the start; result 0xFFFFFFFD (-3), exception 0. A = 100, B = 7 -> 14.
- Divide exceptions:
  - A = 5, B = 0 -> result 0, exception 1, strobe still at 33 cycles.
  - A = 0x80000000, B = -1 -> result 0x80000000, exception 1.
- Control corner cases:
  - ctrl_MULT and ctrl_DIV together with A = 6, B = 3 -> multiply result 18.
  - ctrl_DIV re-pulsed at cycle 10 of a divide -> only one strobe, 33 cycles after the second pulse, carrying the second operation's result.
  - reset asserted at cycle 8 of a multiply -> all outputs 0 and no strobe for 40 cycles.
- Randomized: 200 random operand pairs alternating MULT/DIV, checked against a behavioral model. Each operation must produce exactly one strobe at the exact cycle. Output must be held stable between strobes.

Source files
------------

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 16 steps) / divide (non-restoring, 32 steps)
// unit for the execute stage; answers each accepted start with a one-cycle ready strobe.
module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, stateNext;
  logic [5:0] count;
  logic start;

  logic [31:0] mcand;
  logic [33:0] acc;
  logic [31:0] mq;
  logic prevBit;

  logic [31:0] dvsr;
  logic [33:0] rem;
  logic [31:0] quo;
  logic negQuo, divZero, divOvf;

  logic [31:0] absA, absB;
  logic [33:0] mcExt, boothAdd, boothSum;
  logic [33:0] remShift, remNext;
  logic [63:0] product;
  logic [31:0] divResult;

  assign start = ctrl_MULT | ctrl_DIV;
  assign absA = data_operandA[31] ? -data_operandA : data_operandA;
  assign absB = data_operandB[31] ? -data_operandB : data_operandB;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // A new start wins in every state, with multiply taking priority over divide.
  always_comb begin
    stateNext = state;
    if (ctrl_MULT) stateNext = MUL;
    else if (ctrl_DIV) stateNext = DIV;
    else begin
      case (state)
        IDLE:    stateNext = IDLE;
        MUL:     if (count == 6'd16) stateNext = DONE;
        DIV:     if (count == 6'd32) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    data_resultRDY = (state == DONE);
  end

  // Booth digit from {mq[1:0], prevBit} selects 0, +-M or +-2M.
  always_comb begin
    mcExt = {{2{mcand[31]}}, mcand};
    case ({mq[1:0], prevBit})
      3'b001, 3'b010: boothAdd = mcExt;
      3'b011:         boothAdd = mcExt << 1;
      3'b100:         boothAdd = -(mcExt << 1);
      3'b101, 3'b110: boothAdd = -mcExt;
      default:        boothAdd = 34'd0;
    endcase
    boothSum = acc + boothAdd;
  end

  always_comb begin
    remShift = {rem[32:0], quo[31]};
    remNext  = rem[33] ? remShift + {2'b00, dvsr} : remShift - {2'b00, dvsr};
  end

  assign product   = {acc[31:0], mq};
  assign divResult = negQuo ? -quo : quo;

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= 6'd0;
      mcand   <= 32'd0;
      acc     <= 34'd0;
      mq      <= 32'd0;
      prevBit <= 1'b0;
      dvsr    <= 32'd0;
      rem     <= 34'd0;
      quo     <= 32'd0;
      negQuo  <= 1'b0;
      divZero <= 1'b0;
      divOvf  <= 1'b0;
    end else if (start) begin
      count   <= 6'd0;
      mcand   <= data_operandA;
      acc     <= 34'd0;
      mq      <= data_operandB;
      prevBit <= 1'b0;
      dvsr    <= absB;
      rem     <= 34'd0;
      quo     <= absA;
      negQuo  <= data_operandA[31] ^ data_operandB[31];
      divZero <= (data_operandB == 32'd0);
      divOvf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
    end else if (state == MUL && count != 6'd16) begin
      count   <= count + 6'd1;
      acc     <= {{2{boothSum[33]}}, boothSum[33:2]};
      mq      <= {boothSum[1:0], mq[31:2]};
      prevBit <= mq[1];
    end else if (state == DIV && count != 6'd32) begin
      count <= count + 6'd1;
      rem   <= remNext;
      quo   <= {quo[30:0], ~remNext[33]};
    end
  end

  // Outputs only change on the edge that enters DONE, so they hold between strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (stateNext == DONE) begin
      if (state == MUL) begin
        data_result    <= product[31:0];
        data_exception <= !((&product[63:31]) || !(|product[63:31]));
      end else if (divZero) begin
        data_result    <= 32'd0;
        data_exception <= 1'b1;
      end else if (divOvf) begin
        data_result    <= 32'h8000_0000;
        data_exception <= 1'b1;
      end else begin
        data_result    <= divResult;
        data_exception <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: every start pushes its expected result and strobe cycle,
// and a negedge monitor pops and compares on each strobe while checking outputs hold otherwise.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv dut (
    .clock(clock),
    .reset(reset),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] holdRes = 32'd0;
  logic holdExc = 1'b0;
  bit monEn = 1'b0;

  // Scoreboard monitor: pop on every strobe, otherwise the outputs must hold.
  always @(negedge clock) begin
    exp_t e;
    if (monEn && reset === 1'b0) begin
      checks++;
      if (data_resultRDY === 1'b1) begin
        if (sbq.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_strobe: cyc=%0d result=%h, expected no strobe", cyc, data_result);
        end else begin
          e = sbq.pop_front();
          if (data_result !== e.res || data_exception !== e.exc || cyc != e.due) begin
            failures++;
            $display("[TB] FAIL strobe: got result=%h exc=%b cyc=%0d, expected result=%h exc=%b cyc=%0d",
                     data_result, data_exception, cyc, e.res, e.exc, e.due);
          end
          holdRes = e.res;
          holdExc = e.exc;
        end
      end else if (data_resultRDY !== 1'b0 || data_result !== holdRes || data_exception !== holdExc) begin
        failures++;
        $display("[TB] FAIL hold: cyc=%0d rdy=%b result=%h exc=%b, expected rdy=0 result=%h exc=%b",
                 cyc, data_resultRDY, data_result, data_exception, holdRes, holdExc);
      end
    end
  end

  function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p > 64'sd2147483647 || p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    int v;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin v = $urandom_range(0, 200); return 32'(v - 100); end
      2: return 32'($urandom_range(0, 65535));
      default: return sp[$urandom_range(0, 4)];
    endcase
  endfunction

  // Called just after a rising edge; the start is sampled on the following edge.
  task automatic drive_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input logic exc);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    e.res = res;
    e.exc = exc;
    e.due = cyc + 1 + (m ? 17 : 33);
    sbq.push_back(e);
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    ok = (sbq.size() == 0);
    if (!ok) sbq.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: result=%h exc=%b rdy=%b, expected 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    reset = 1'b0;
    holdRes = 32'd0;
    holdExc = 1'b0;
    monEn = 1'b1;
  endtask

  task automatic test_multiply();
    logic [31:0] va [4] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] vb [4] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] vr [4] = '{32'hFFFF_FFEB, 32'd0, 32'd1, 32'hFFFF_FFFE};
    logic ve [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      drive_start(1'b1, 1'b0, va[i], vb[i], vr[i], ve[i]);
      wait_drain(40, ok);
      checks++;
      if (!ok || data_result !== vr[i] || data_exception !== ve[i]) begin
        failures++;
        $display("[TB] FAIL mult_%0d: done=%b result=%h exc=%b, expected result=%h exc=%b",
                 i, ok, data_result, data_exception, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [31:0] va [7] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF9C, 32'd7};
    logic [31:0] vb [7] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF9, 32'hFFFF_FFFE};
    logic [31:0] vr [7] = '{32'hFFFF_FFFD, 32'd14, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD};
    logic ve [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit ok;
    for (int i = 0; i < 7; i++) begin
      drive_start(1'b0, 1'b1, va[i], vb[i], vr[i], ve[i]);
      wait_drain(60, ok);
      checks++;
      if (!ok || data_result !== vr[i] || data_exception !== ve[i]) begin
        failures++;
        $display("[TB] FAIL div_%0d: done=%b result=%h exc=%b, expected result=%h exc=%b",
                 i, ok, data_result, data_exception, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    drive_start(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
    wait_drain(40, ok);
    checks++;
    if (!ok || data_result !== 32'd18 || data_exception !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simultaneous: done=%b result=%h exc=%b, expected result=00000012 exc=0",
               ok, data_result, data_exception);
    end
  endtask

  task automatic test_restart();
    bit ok;
    int k;
    drive_start(1'b0, 1'b1, 32'd1000, 32'd10, 32'd100, 1'b0);
    k = cyc;
    while (cyc < k + 9) begin @(posedge clock); #1; end
    sbq.delete();
    drive_start(1'b0, 1'b1, 32'hFFFF_FFCE, 32'd5, 32'hFFFF_FFF6, 1'b0);
    wait_drain(60, ok);
    checks++;
    if (!ok || data_result !== 32'hFFFF_FFF6) begin
      failures++;
      $display("[TB] FAIL restart: done=%b result=%h, expected result=fffffff6", ok, data_result);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    drive_start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    k = cyc;
    while (cyc < k + 17) begin @(posedge clock); #1; end
    drive_start(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
    wait_drain(60, ok);
    checks++;
    if (!ok || data_result !== 32'd14) begin
      failures++;
      $display("[TB] FAIL back_to_back: done=%b result=%h, expected result=0000000e", ok, data_result);
    end
  endtask

  task automatic test_reset_midop();
    int k;
    int strobes = 0;
    drive_start(1'b1, 1'b0, 32'd12345, 32'd678, 32'd8369910, 1'b0);
    k = cyc;
    while (cyc < k + 7) begin @(posedge clock); #1; end
    reset = 1'b1;
    sbq.delete();
    holdRes = 32'd0;
    holdExc = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midop_state: result=%h exc=%b rdy=%b, expected 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) strobes++;
    end
    @(posedge clock); #1;
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("[TB] FAIL reset_midop_strobe: strobes=%0d, expected 0", strobes);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [32:0] r;
    logic m;
    bit ok;
    for (int i = 0; i < 200; i++) begin
      m = (i % 2 == 0);
      a = pick();
      b = pick();
      if (!m && $urandom_range(0, 15) == 0) b = 32'd0;
      r = model(m, a, b);
      drive_start(m, !m, a, b, r[31:0], r[32]);
      wait_drain(60, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL random_%0d: no strobe within budget, a=%h b=%h mult=%b", i, a, b, m);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    test_reset();
    test_multiply();
    test_divide();
    test_simultaneous();
    test_restart();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
